// File: rtl/processor_pin_sequencer.sv
// processor_pin_sequencer
//
// Purpose:
//   Pattern sequencer that owns the output PIO. The CPU loads up to eight
//   patterns and a step period over an Avalon-MM slave port, then sets RUN.
//   The block then issues single-cycle Avalon writes to the PIO data register
//   at the programmed rate, either once through the pattern list or looping.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address             CPU slave word address (4 bits)
//   chipselect,write_n  CPU slave select and active-low write strobe
//   writedata           CPU slave write data (32 bits)
//   readdata            CPU slave read data, combinational on address
//   pio_address         PIO s1 address, tied to 0
//   pio_chipselect      PIO s1 chipselect, high for one cycle per step
//   pio_write_n         PIO s1 write strobe, active low
//   pio_writedata       PIO s1 write data, pattern zero-extended to 32 bits
//   irq                 DONE & IRQ_EN
//
// Register map:
//   0 CTRL    [0] RUN, [1] LOOP, [2] IRQ_EN, [6:4] LEN (steps = LEN+1)
//   1 PERIOD  cycles between PIO writes (0 and 1 behave as 2)
//   2 STATUS  [0] BUSY, [1] DONE (write 1 to clear), [4:2] STEP
//   8..15     PAT[0..7]
module processor_pin_sequencer #(
  parameter int PIO_WIDTH = 3,
  parameter int DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        irq
);

  localparam int PAT_PAD = 32 - PIO_WIDTH;
  localparam int PER_PAD = 32 - DIV_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT
  } state_t;

  state_t               state;
  logic                 run;
  logic                 loop;
  logic                 irq_en;
  logic [2:0]           len_reg;
  logic [2:0]           len_q;
  logic [DIV_WIDTH-1:0] period;
  logic [DIV_WIDTH-1:0] cnt;
  logic                 done;
  logic [2:0]           step;
  logic [PIO_WIDTH-1:0] pat [8];

  logic cpu_wr;
  logic ctrl_wr;
  logic period_wr;
  logic status_wr;
  logic pat_wr;
  logic start;
  logic abort;
  logic busy;

  // Upper write-data bits have no register behind them.
  logic unused_writedata;

  assign cpu_wr    = chipselect & ~write_n;
  assign ctrl_wr   = cpu_wr && (address == 4'd0);
  assign period_wr = cpu_wr && (address == 4'd1);
  assign status_wr = cpu_wr && (address == 4'd2);
  assign pat_wr    = cpu_wr && address[3];
  assign start     = ctrl_wr & writedata[0];
  assign abort     = ctrl_wr & ~writedata[0];
  assign busy      = (state != IDLE);

  assign unused_writedata = &{1'b0, writedata[31:DIV_WIDTH]};

  assign pio_address = 2'b00;
  assign irq         = done & irq_en;

  // CPU read mux; zero-wait so it is purely combinational on address.
  always_comb begin
    readdata = '0;
    case (address)
      4'd0: readdata = {25'b0, len_reg, 1'b0, irq_en, loop, run};
      4'd1: readdata = {{PER_PAD{1'b0}}, period};
      4'd2: readdata = {27'b0, step, done, busy};
      default: begin
        if (address[3]) begin
          readdata = {{PAT_PAD{1'b0}}, pat[address[2:0]]};
        end
      end
    endcase
  end

  // Register file and sequencing FSM. Register writes come first so that
  // the FSM's own updates (completion clearing RUN, setting DONE) override
  // a CPU write landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      run            <= 1'b0;
      loop           <= 1'b0;
      irq_en         <= 1'b0;
      len_reg        <= '0;
      len_q          <= '0;
      period         <= '0;
      cnt            <= '0;
      done           <= 1'b0;
      step           <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
      for (int i = 0; i < 8; i++) begin
        pat[i] <= '0;
      end
    end else begin
      if (ctrl_wr) begin
        run     <= writedata[0];
        loop    <= writedata[1];
        irq_en  <= writedata[2];
        len_reg <= writedata[6:4];
      end
      if (period_wr) begin
        period <= writedata[DIV_WIDTH-1:0];
      end
      if (status_wr && writedata[1]) begin
        done <= 1'b0;
      end
      if (pat_wr) begin
        pat[address[2:0]] <= writedata[PIO_WIDTH-1:0];
      end

      case (state)
        IDLE: begin
          if (start) begin
            len_q          <= writedata[6:4];
            step           <= '0;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= {{PAT_PAD{1'b0}}, pat[0]};
            state          <= WRITE;
          end
        end

        WRITE: begin
          // The strobe is only ever one cycle wide. Counting down from
          // PERIOD-2 in WAIT gives max(PERIOD,2) cycles between strobes.
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          cnt            <= (period < DIV_WIDTH'(2)) ? '0 : period - DIV_WIDTH'(2);
          state          <= abort ? IDLE : WAIT;
        end

        WAIT: begin
          if (abort) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - DIV_WIDTH'(1);
          end else if (step < len_q) begin
            step           <= step + 3'd1;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= {{PAT_PAD{1'b0}}, pat[step + 3'd1]};
            state          <= WRITE;
          end else if (loop) begin
            step           <= '0;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= {{PAT_PAD{1'b0}}, pat[0]};
            state          <= WRITE;
          end else begin
            run   <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
